sram_access_ctrl: RTL and testbench

Initiator for the single-port `Sram` block. It accepts byte, halfword and word load/store requests from the MIPS core's memory stage through a valid/ready handshake and drives the Sram En/RW/Addr/Data_In pins. It captures Sram Data_Out and returns aligned, sign- or zero-extended load data. Sub-word stores use read-modify-write, because the Sram has no byte enables. It sits between the core's MEM stage and the data Sram.

---
 rtl/sram_access_ctrl.sv | 151 +++++++++++++++
 tb/tb_sram_access_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sram_access_ctrl.sv
// Load/store initiator for the single-port data Sram: big-endian byte lanes,
// sign/zero-extended loads, read-modify-write for byte and halfword stores.
module sram_access_ctrl #(
    parameter int D_WIDTH  = 32,
    parameter int SA_WIDTH = 8
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Req_Valid,
    output logic                  Req_Ready,
    input  logic                  Req_Write,
    input  logic [1:0]            Req_Size,
    input  logic                  Req_Signed,
    input  logic [SA_WIDTH+1:0]   Req_Addr,
    input  logic [D_WIDTH-1:0]    Req_Wdata,
    output logic                  Rsp_Valid,
    output logic                  Rsp_Err,
    output logic [D_WIDTH-1:0]    Rsp_Rdata,
    output logic                  Mem_En,
    output logic                  Mem_RW,
    output logic [SA_WIDTH-1:0]   Mem_Addr,
    output logic [D_WIDTH-1:0]    Mem_Din,
    input  logic [D_WIDTH-1:0]    Mem_Dout
);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_RESP} state_t;

    state_t                state_q, state_d;
    logic                  wr_q;
    logic [1:0]            size_q;
    logic                  sgn_q;
    logic [1:0]            off_q;
    logic [SA_WIDTH-1:0]   addr_q;
    logic [15:0]           wdata_q;
    logic [D_WIDTH-1:0]    din_q;
    logic [D_WIDTH-1:0]    rdata_q;
    logic                  err_q;

    logic                  accept;
    logic                  req_err;
    logic                  req_wstore;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [D_WIDTH-1:0]    load_val;
    logic [D_WIDTH-1:0]    merged;

    assign accept      = Req_Valid && (state_q == S_IDLE);
    assign req_wstore  = Req_Write && (Req_Size == 2'b10);

    always_comb begin
        req_err = 1'b0;
        case (Req_Size)
            2'b01:   req_err = Req_Addr[0];
            2'b10:   req_err = (Req_Addr[1:0] != 2'b00);
            2'b11:   req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
    end

    // Big-endian: offset 0 is the most significant byte/half of the word.
    always_comb begin
        byte_sel = '0;
        case (off_q)
            2'd0:    byte_sel = Mem_Dout[31:24];
            2'd1:    byte_sel = Mem_Dout[23:16];
            2'd2:    byte_sel = Mem_Dout[15:8];
            default: byte_sel = Mem_Dout[7:0];
        endcase
        half_sel = off_q[1] ? Mem_Dout[15:0] : Mem_Dout[31:16];

        load_val = Mem_Dout;
        merged   = Mem_Dout;
        case (size_q)
            2'b00: begin
                load_val = {{24{sgn_q & byte_sel[7]}}, byte_sel};
                case (off_q)
                    2'd0:    merged[31:24] = wdata_q[7:0];
                    2'd1:    merged[23:16] = wdata_q[7:0];
                    2'd2:    merged[15:8]  = wdata_q[7:0];
                    default: merged[7:0]   = wdata_q[7:0];
                endcase
            end
            2'b01: begin
                load_val = {{16{sgn_q & half_sel[15]}}, half_sel};
                if (off_q[1]) merged[15:0]  = wdata_q;
                else          merged[31:16] = wdata_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (Req_Valid) begin
                    if (req_err)         state_d = S_RESP;
                    else if (req_wstore) state_d = S_WRITE;
                    else                 state_d = S_READ;
                end
            end
            S_READ:  state_d = S_WAIT;
            S_WAIT:  state_d = wr_q ? S_WRITE : S_RESP;
            S_WRITE: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_q    <= 1'b0;
            size_q  <= '0;
            sgn_q   <= 1'b0;
            off_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            din_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            wr_q    <= Req_Write;
            size_q  <= Req_Size;
            sgn_q   <= Req_Signed;
            off_q   <= Req_Addr[1:0];
            addr_q  <= Req_Addr[SA_WIDTH+1:2];
            wdata_q <= Req_Wdata[15:0];
            err_q   <= req_err;
            if (req_err)                rdata_q <= '0;
            else if (req_wstore)        din_q   <= Req_Wdata;
        end else if (state_q == S_WAIT) begin
            if (wr_q) din_q   <= merged;
            else      rdata_q <= load_val;
        end
    end

    assign Req_Ready = (state_q == S_IDLE);
    assign Rsp_Valid = (state_q == S_RESP);
    assign Rsp_Err   = (state_q == S_RESP) && err_q;
    assign Rsp_Rdata = rdata_q;
    assign Mem_En    = (state_q == S_READ) || (state_q == S_WRITE);
    assign Mem_RW    = (state_q == S_WRITE);
    assign Mem_Addr  = addr_q;
    assign Mem_Din   = din_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl with a behavioural synchronous-read Sram.
module tb_sram_access_ctrl;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Req_Valid = 1'b0;
    logic        Req_Ready;
    logic        Req_Write = 1'b0;
    logic [1:0]  Req_Size = 2'b00;
    logic        Req_Signed = 1'b0;
    logic [9:0]  Req_Addr = '0;
    logic [31:0] Req_Wdata = '0;
    logic        Rsp_Valid;
    logic        Rsp_Err;
    logic [31:0] Rsp_Rdata;
    logic        Mem_En;
    logic        Mem_RW;
    logic [7:0]  Mem_Addr;
    logic [31:0] Mem_Din;
    logic [31:0] Mem_Dout = '0;

    logic [31:0] mem [0:255];
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          checks = 0;
    int          failures = 0;

    sram_access_ctrl #(.D_WIDTH(32), .SA_WIDTH(8)) dut (
        .Clk(Clk), .Rst(Rst),
        .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_Write(Req_Write),
        .Req_Size(Req_Size), .Req_Signed(Req_Signed), .Req_Addr(Req_Addr),
        .Req_Wdata(Req_Wdata), .Rsp_Valid(Rsp_Valid), .Rsp_Err(Rsp_Err),
        .Rsp_Rdata(Rsp_Rdata), .Mem_En(Mem_En), .Mem_RW(Mem_RW),
        .Mem_Addr(Mem_Addr), .Mem_Din(Mem_Din), .Mem_Dout(Mem_Dout)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (Mem_En) begin
            if (Mem_RW) begin
                mem[Mem_Addr] <= Mem_Din;
                wr_cnt <= wr_cnt + 1;
            end else begin
                Mem_Dout <= mem[Mem_Addr];
                rd_cnt <= rd_cnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issues one request; returns edges from accept to Rsp_Valid plus Sram access counts.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [9:0] a, input logic [31:0] wd, input bit hold,
                          output int lat, output int nrd, output int nwr,
                          output logic err, output logic [31:0] rdata);
        int r0, w0;
        r0 = rd_cnt;
        w0 = wr_cnt;
        @(negedge Clk);
        Req_Write = w; Req_Size = sz; Req_Signed = sg; Req_Addr = a; Req_Wdata = wd;
        Req_Valid = 1'b1;
        @(posedge Clk); #1;
        if (!hold) Req_Valid = 1'b0;
        lat = 1;
        while (!Rsp_Valid && lat < 20) begin
            if (hold) begin
                chk("ready_busy", {31'b0, Req_Ready}, 32'd0);
                Req_Addr = Req_Addr + 10'h14;
                Req_Wdata = ~Req_Wdata;
            end
            @(posedge Clk); #1;
            lat++;
        end
        if (hold) begin
            chk("ready_resp", {31'b0, Req_Ready}, 32'd0);
            Req_Valid = 1'b0;
        end
        nrd = rd_cnt - r0;
        nwr = wr_cnt - w0;
        err = Rsp_Err;
        rdata = Rsp_Rdata;
        @(posedge Clk); #1;
    endtask

    typedef struct {
        string       tag;
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [9:0]  a;
        logic [31:0] wd;
        int          lat;
        int          nrd;
        int          nwr;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] word4;
    } vec_t;

    vec_t vecs [$];

    initial begin
        int lat, nrd, nwr, w0, seen;
        logic err;
        logic [31:0] rdata;

        vecs.push_back('{"sw",      1, 2'b10, 0, 10'h10, 32'hDEADBEEF, 2, 0, 1, 0, 32'h0,        32'hDEADBEEF});
        vecs.push_back('{"lw",      0, 2'b10, 0, 10'h10, 32'h0,        3, 1, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF});
        vecs.push_back('{"lb11",    0, 2'b00, 1, 10'h11, 32'h0,        3, 1, 0, 0, 32'hFFFFFFAD, 32'hDEADBEEF});
        vecs.push_back('{"lbu13",   0, 2'b00, 0, 10'h13, 32'h0,        3, 1, 0, 0, 32'h000000EF, 32'hDEADBEEF});
        vecs.push_back('{"lh12",    0, 2'b01, 1, 10'h12, 32'h0,        3, 1, 0, 0, 32'hFFFFBEEF, 32'hDEADBEEF});
        vecs.push_back('{"lhu10",   0, 2'b01, 0, 10'h10, 32'h0,        3, 1, 0, 0, 32'h0000DEAD, 32'hDEADBEEF});
        vecs.push_back('{"sb12",    1, 2'b00, 0, 10'h12, 32'hFFFFFF12, 4, 1, 1, 0, 32'h0000DEAD, 32'hDEAD12EF});
        vecs.push_back('{"sh10",    1, 2'b01, 0, 10'h10, 32'hABCD3456, 4, 1, 1, 0, 32'h0000DEAD, 32'h345612EF});
        vecs.push_back('{"lw2",     0, 2'b10, 0, 10'h10, 32'h0,        3, 1, 0, 0, 32'h345612EF, 32'h345612EF});
        vecs.push_back('{"lh_mis",  0, 2'b01, 1, 10'h11, 32'h0,        1, 0, 0, 1, 32'h0,        32'h345612EF});
        vecs.push_back('{"sw_mis",  1, 2'b10, 0, 10'h12, 32'h11111111, 1, 0, 0, 1, 32'h0,        32'h345612EF});
        vecs.push_back('{"sz11",    0, 2'b11, 0, 10'h10, 32'h0,        1, 0, 0, 1, 32'h0,        32'h345612EF});

        #2;
        chk("rst_ready", {31'b0, Req_Ready}, 32'd1);
        chk("rst_en",    {31'b0, Mem_En},    32'd0);
        chk("rst_rw",    {31'b0, Mem_RW},    32'd0);
        chk("rst_addr",  {24'b0, Mem_Addr},  32'd0);
        chk("rst_din",   Mem_Din,            32'd0);
        chk("rst_valid", {31'b0, Rsp_Valid}, 32'd0);
        chk("rst_err",   {31'b0, Rsp_Err},   32'd0);
        chk("rst_rdata", Rsp_Rdata,          32'd0);
        @(negedge Clk);
        Rst = 1'b1;

        foreach (vecs[i]) begin
            do_req(vecs[i].w, vecs[i].sz, vecs[i].sg, vecs[i].a, vecs[i].wd, 1'b0,
                   lat, nrd, nwr, err, rdata);
            chk({vecs[i].tag, "_lat"},   lat,               vecs[i].lat);
            chk({vecs[i].tag, "_rd"},    nrd,               vecs[i].nrd);
            chk({vecs[i].tag, "_wr"},    nwr,               vecs[i].nwr);
            chk({vecs[i].tag, "_err"},   {31'b0, err},      {31'b0, vecs[i].err});
            chk({vecs[i].tag, "_rdata"}, rdata,             vecs[i].rdata);
            chk({vecs[i].tag, "_word4"}, mem[4],            vecs[i].word4);
        end

        // Req_Valid held high while the address wanders: only the latched word 4 is read.
        do_req(1'b0, 2'b10, 1'b0, 10'h10, 32'h0, 1'b1, lat, nrd, nwr, err, rdata);
        chk("hold_lat",   lat,   32'd3);
        chk("hold_rdata", rdata, 32'h345612EF);
        chk("hold_rd",    nrd,   32'd1);
        chk("hold_idle",  {31'b0, Req_Ready}, 32'd1);

        // Reset asserted in WAIT of a byte store: the pending write must be dropped.
        w0 = wr_cnt;
        @(negedge Clk);
        Req_Write = 1'b1; Req_Size = 2'b00; Req_Signed = 1'b0; Req_Addr = 10'h10;
        Req_Wdata = 32'h000000AA; Req_Valid = 1'b1;
        @(posedge Clk); #1;
        Req_Valid = 1'b0;
        @(posedge Clk); #1;
        Rst = 1'b0;
        #1;
        chk("mid_rst_en",    {31'b0, Mem_En},    32'd0);
        chk("mid_rst_ready", {31'b0, Req_Ready}, 32'd1);
        chk("mid_rst_din",   Mem_Din,            32'd0);
        chk("mid_rst_addr",  {24'b0, Mem_Addr},  32'd0);
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge Clk); #1;
            if (Rsp_Valid) seen++;
        end
        chk("post_rst_wr",    wr_cnt - w0,        32'd0);
        chk("post_rst_rsp",   seen,               32'd0);
        chk("post_rst_word4", mem[4],             32'h345612EF);
        chk("post_rst_ready", {31'b0, Req_Ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
